mem_test_seq: RTL and testbench
===============================

MEM_TEST_SEQ -- requirements
Module: mem_test_seq

Interface
REQ-001 SHALL have parameter NUM_ITERS, default 16: iterations per run; 0 means run until stop.
REQ-002 SHALL have parameter RESET_CYCLES, default 4: cycles the tester is held in reset before each iteration; legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: per-iteration watchdog limit; used only when MEM_TEST_SEQ_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE or DONE.
REQ-007 SHALL have port stop, input, 1 bit: request the run to end after the current iteration.
REQ-008 SHALL have port tester_rst_n, output, 1 bit: active-low reset driven to the AXI memory tester.
REQ-009 SHALL have port tester_done, input, 1 bit: tester one-cycle done pulse.
REQ-010 SHALL have port tester_pass, input, 1 bit: tester pass level; 0 means the tester is failed (sticky until its reset).
REQ-011 SHALL have port busy, output, 1 bit: 1 in RESET or RUN.
REQ-012 SHALL have port done, output, 1 bit: 1 in DONE.
REQ-013 SHALL have port pass, output, 1 bit: in DONE, 1 iff fail_cnt==0; 0 outside DONE.
REQ-014 SHALL have port iter_cnt, output, 16 bits: completed iterations this run.
REQ-015 SHALL have port fail_cnt, output, 16 bits: failed iterations (data mismatch or timeout) this run.
REQ-016 SHALL have port timeout_seen, output, 1 bit: sticky; 1 if any iteration this run timed out.

Function
REQ-017 SHALL implement states IDLE, RESET, RUN, DONE.
REQ-018 IDLE/DONE: start=1 SHALL clear iter_cnt, fail_cnt, timeout_seen and the stop request, then enter RESET next cycle.
REQ-019 RESET: tester_rst_n SHALL be 0 for exactly RESET_CYCLES cycles, then the FSM enters RUN with the watchdog cleared.
REQ-020 RUN: tester_rst_n SHALL be 1; in IDLE, RESET and DONE tester_rst_n SHALL be 0.
REQ-021 RUN completion, priority high to low: tester_pass==0 -> fail; tester_done==1 -> pass; watchdog reaches TIMEOUT_CYCLES-1 -> fail plus timeout_seen=1.
- Any completion SHALL increment iter_cnt by 1.
- A failing completion SHALL also increment fail_cnt by 1.
- Both counters SHALL saturate at 0xFFFF.
REQ-022 After a completion, the FSM SHALL enter DONE if any of the following holds, otherwise RESET:
- NUM_ITERS!=0 and the incremented iter_cnt==NUM_ITERS;
- a stop request is pending;
- stop=1 in the completion cycle.
REQ-023 stop=1 in RESET or RUN SHALL latch a stop request; the iteration in flight SHALL still complete and be counted.
REQ-024 start in RESET or RUN SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-025 tester_done and tester_pass SHALL be ignored outside RUN.
REQ-026 Completion latency: a RUN completion on cycle N SHALL be visible in the counters on N+1; with NUM_ITERS reached, done=1 on N+1.
REQ-027 Watchdog SHALL be a 32-bit counter that increments every RUN cycle and clears on RUN entry.

Reset
REQ-028 While rst_n=0, the block SHALL force: state=IDLE, tester_rst_n=0, busy=0, done=0, pass=0, iter_cnt=0, fail_cnt=0, timeout_seen=0, stop request cleared.
REQ-029 rst_n=0 mid-run SHALL abort the run with no DONE pulse and SHALL hold the tester in reset.

Configuration
REQ-030 Macro MEM_TEST_SEQ_TIMEOUT_EN:
- defined -> the watchdog SHALL behave per REQ-021 and REQ-027;
- undefined -> no watchdog logic SHALL exist, a RUN iteration SHALL wait indefinitely, and timeout_seen SHALL be tied to 0.

Verification
REQ-031 NUM_ITERS=3, tester model pulses done 10 cycles after release, start pulse -> three RESET (4 cycles) plus RUN cycles, then done=1, pass=1, iter_cnt=3, fail_cnt=0.
REQ-032 NUM_ITERS=3, second iteration drives tester_pass=0 -> iter_cnt=3, fail_cnt=1, pass=0, and tester_rst_n pulsed low before iteration 3.
REQ-033 TIMEOUT_EN defined, TIMEOUT_CYCLES=20, tester never done -> each iteration lasts 20 RUN cycles, fail_cnt=iter_cnt=NUM_ITERS, timeout_seen=1.
REQ-034 NUM_ITERS=0, stop pulsed during iteration 5 RUN -> DONE after iteration 5 completes, iter_cnt=5; start in DONE restarts with counters cleared.
REQ-035 rst_n asserted mid-RUN of iteration 2 -> next cycle state=IDLE, tester_rst_n=0, all counters 0, done=0.
REQ-036 start pulsed during RUN, plus tester_done and tester_pass=0 in the same cycle -> start ignored, that iteration counted as fail.

Source files
------------

// File: rtl/mem_test_seq.sv
// Sequencer that repeatedly resets and runs an AXI memory tester, counting completed and failed iterations.
// Optional per-iteration watchdog enabled by defining MEM_TEST_SEQ_TIMEOUT_EN.
module mem_test_seq #(
  parameter int NUM_ITERS      = 16,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        tester_rst_n,
  input  logic        tester_done,
  input  logic        tester_pass,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] iter_cnt,
  output logic [15:0] fail_cnt,
  output logic        timeout_seen
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_NUM_ITERS = 16'(NUM_ITERS);
  localparam logic [7:0]  LP_RST_LAST  = 8'(RESET_CYCLES - 1);
  localparam bit          LP_BOUNDED   = (NUM_ITERS != 0);

  state_t      r_state;
  logic [7:0]  r_rst_cnt;
  logic [15:0] r_iter;
  logic [15:0] r_fail;
  logic        r_stop_req;
  logic        r_trst_n;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic        w_timeout;
  logic        w_complete;
  logic        w_failed;
  logic        w_tmo_fail;
  logic [15:0] w_iter_inc;
  logic [15:0] w_fail_inc;
  logic [15:0] w_fail_next;
  logic        w_last;

`ifdef MEM_TEST_SEQ_TIMEOUT_EN
  localparam logic [31:0] LP_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_wdog;
  logic        r_tmo;

  // Watchdog is held at zero outside RUN so every RUN entry starts from a clean count.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_RUN) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  assign w_timeout    = (r_wdog == LP_TMO_LAST);
  assign timeout_seen = r_tmo;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign timeout_seen     = 1'b0;
`endif

  // Completion priority: tester failure, then tester done, then watchdog expiry.
  assign w_complete  = !tester_pass || tester_done || w_timeout;
  assign w_failed    = !tester_pass || (!tester_done && w_timeout);
  assign w_tmo_fail  = tester_pass && !tester_done && w_timeout;
  assign w_iter_inc  = (r_iter == 16'hFFFF) ? r_iter : r_iter + 16'd1;
  assign w_fail_inc  = (r_fail == 16'hFFFF) ? r_fail : r_fail + 16'd1;
  assign w_fail_next = w_failed ? w_fail_inc : r_fail;
  assign w_last      = (LP_BOUNDED && (w_iter_inc == LP_NUM_ITERS)) || r_stop_req || stop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rst_cnt  <= '0;
      r_iter     <= '0;
      r_fail     <= '0;
      r_stop_req <= 1'b0;
      r_trst_n   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
`ifdef MEM_TEST_SEQ_TIMEOUT_EN
      r_tmo      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_RESET;
            r_rst_cnt  <= '0;
            r_iter     <= '0;
            r_fail     <= '0;
            r_stop_req <= 1'b0;
            r_trst_n   <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
`ifdef MEM_TEST_SEQ_TIMEOUT_EN
            r_tmo      <= 1'b0;
`endif
          end
        end
        S_RESET: begin
          if (stop) begin
            r_stop_req <= 1'b1;
          end
          if (r_rst_cnt == LP_RST_LAST) begin
            r_state  <= S_RUN;
            r_trst_n <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_stop_req <= 1'b1;
          end
          if (w_complete) begin
            r_iter    <= w_iter_inc;
            r_fail    <= w_fail_next;
            r_trst_n  <= 1'b0;
            r_rst_cnt <= '0;
`ifdef MEM_TEST_SEQ_TIMEOUT_EN
            if (w_tmo_fail) begin
              r_tmo <= 1'b1;
            end
`endif
            // The in-flight iteration is always counted before honouring a stop request.
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_fail_next == 16'd0);
            end else begin
              r_state <= S_RESET;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tester_rst_n = r_trst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign iter_cnt     = r_iter;
  assign fail_cnt     = r_fail;

`ifndef MEM_TEST_SEQ_TIMEOUT_EN
  logic w_unused_tmo_flag;
  assign w_unused_tmo_flag = w_tmo_fail;
`endif

endmodule

// File: tb/tb_mem_test_seq.sv
// Scoreboard bench for mem_test_seq: a bounded-run instance (3 iterations) and a free-running instance stopped by request.
module tb_mem_test_seq;

  typedef struct {
    logic [15:0] it;
    logic [15:0] fl;
    logic        dn;
    logic        tm;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mainStartA;
  logic        mStartA;
  logic        startA;
  logic        stopA;
  logic        trstA;
  logic        tDoneA;
  logic        tPassA;
  logic        busyA;
  logic        doneA;
  logic        passA;
  logic [15:0] iterA;
  logic [15:0] failA;
  logic        tmoA;

  logic        startB;
  logic        stopB;
  logic        trstB;
  logic        tDoneB;
  logic        busyB;
  logic        doneB;
  logic        passB;
  logic [15:0] iterB;
  logic [15:0] failB;
  logic        tmoB;

  int          errCount;
  int          checkCount;
  int          cyc;
  int          relA;
  int          lowA;
  int          iterNo;
  int          modeA;
  int          failIter;
  int          sameIter;
  int          expIter;
  int          expFail;
  logic        expTmo;
  int          relB;
  logic [15:0] prevIterA;
  exp_t        sbQ[$];

  assign startA = mainStartA | mStartA;

  mem_test_seq #(
    .NUM_ITERS     (3),
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(20)
  ) dutA (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (startA),
    .stop        (stopA),
    .tester_rst_n(trstA),
    .tester_done (tDoneA),
    .tester_pass (tPassA),
    .busy        (busyA),
    .done        (doneA),
    .pass        (passA),
    .iter_cnt    (iterA),
    .fail_cnt    (failA),
    .timeout_seen(tmoA)
  );

  mem_test_seq #(
    .NUM_ITERS     (0),
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(20)
  ) dutB (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (startB),
    .stop        (stopB),
    .tester_rst_n(trstB),
    .tester_done (tDoneB),
    .tester_pass (1'b1),
    .busy        (busyB),
    .done        (doneB),
    .pass        (passB),
    .iter_cnt    (iterB),
    .fail_cnt    (failB),
    .timeout_seen(tmoB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One cycle: scoreboard pop on counter increments, then tester models drive the next cycle.
  task automatic tick();
    exp_t e;
    logic completing;
    logic failing;
    @(negedge clk);
    cyc++;
    if (iterA > prevIterA) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_iter", 32'(iterA), 32'(prevIterA));
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_iter", 32'(iterA), 32'(e.it));
        checkOutput("sb_fail", 32'(failA), 32'(e.fl));
        checkOutput("sb_done", 32'(doneA), 32'(e.dn));
        checkOutput("sb_pass", 32'(passA), 32'(e.dn && (e.fl == 16'd0)));
        checkOutput("sb_tmo", 32'(tmoA), 32'(e.tm));
        checkOutput("sb_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    prevIterA = iterA;

    tDoneA  = 1'b0;
    mStartA = 1'b0;
    completing = 1'b0;
    failing    = 1'b0;
    if (!trstA) begin
      relA   = 0;
      tPassA = 1'b1;
      if (busyA) lowA++;
      else lowA = 0;
    end else begin
      relA++;
      if (relA == 1) begin
        iterNo++;
        checkOutput("rst_len", 32'(lowA), 32'd4);
        lowA = 0;
      end
      if (iterNo == sameIter && relA == 10) begin
        tDoneA = 1'b1;
        tPassA = 1'b0;
        mStartA = 1'b1;
        completing = 1'b1;
        failing = 1'b1;
      end else if (iterNo == failIter && relA == 5) begin
        tPassA = 1'b0;
        completing = 1'b1;
        failing = 1'b1;
      end else if (modeA == 0 && relA == 10) begin
        tDoneA = 1'b1;
        completing = 1'b1;
`ifdef MEM_TEST_SEQ_TIMEOUT_EN
      end else if (relA == 20) begin
        completing = 1'b1;
        failing = 1'b1;
        expTmo = 1'b1;
`endif
      end
      if (completing) begin
        expIter++;
        if (failing) expFail++;
        e.it  = 16'(expIter);
        e.fl  = 16'(expFail);
        e.dn  = (expIter == 3);
        e.tm  = expTmo;
        e.cyc = cyc + 1;
        sbQ.push_back(e);
      end
    end

    if (!trstB) relB = 0;
    else relB++;
    tDoneB = (relB == 3);
  endtask

  task automatic applyStimulus();
    expIter = 0;
    expFail = 0;
    expTmo  = 1'b0;
    iterNo  = 0;
    sbQ.delete();
    mainStartA = 1'b1;
    tick();
    mainStartA = 1'b0;
    checkOutput("start_busy", 32'(busyA), 32'd1);
    checkOutput("start_iter_clr", 32'(iterA), 32'd0);
    checkOutput("start_fail_clr", 32'(failA), 32'd0);
  endtask

  task automatic finishRunA(input int expF, input logic expT);
    int n;
    n = 0;
    while (!doneA && n < 400) begin
      tick();
      n++;
    end
    checkOutput("runA_done", 32'(doneA), 32'd1);
    checkOutput("runA_iter", 32'(iterA), 32'd3);
    checkOutput("runA_fail", 32'(failA), 32'(expF));
    checkOutput("runA_pass", 32'(passA), 32'(expF == 0));
    checkOutput("runA_tmo", 32'(tmoA), 32'(expT));
    checkOutput("runA_busy", 32'(busyA), 32'd0);
    checkOutput("runA_trst", 32'(trstA), 32'd0);
    checkOutput("runA_sb_empty", 32'(sbQ.size()), 32'd0);
    tick();
    tick();
    checkOutput("runA_hold_done", 32'(doneA), 32'd1);
    checkOutput("runA_hold_iter", 32'(iterA), 32'd3);
  endtask

  task automatic waitDoneB(input string tag);
    int n;
    n = 0;
    while (!doneB && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(doneB), 32'd1);
  endtask

  initial begin
    int n;
    errCount = 0;
    checkCount = 0;
    cyc = 0;
    relA = 0;
    lowA = 0;
    iterNo = 0;
    modeA = 0;
    failIter = 0;
    sameIter = 0;
    expIter = 0;
    expFail = 0;
    expTmo = 1'b0;
    relB = 0;
    prevIterA = '0;
    rst_n = 1'b0;
    mainStartA = 1'b0;
    mStartA = 1'b0;
    stopA = 1'b0;
    tDoneA = 1'b0;
    tPassA = 1'b1;
    startB = 1'b0;
    stopB = 1'b0;
    tDoneB = 1'b0;

    repeat (3) tick();
    checkOutput("rst_trst", 32'(trstA), 32'd0);
    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_pass", 32'(passA), 32'd0);
    checkOutput("rst_iter", 32'(iterA), 32'd0);
    checkOutput("rst_fail", 32'(failA), 32'd0);
    checkOutput("rst_tmo", 32'(tmoA), 32'd0);
    checkOutput("rst_busyB", 32'(busyB), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean three-iteration run.
    applyStimulus();
    finishRunA(0, 1'b0);

    // Second iteration reports a data failure.
    failIter = 2;
    applyStimulus();
    finishRunA(1, 1'b0);

    // Start, done and a failing pass level all arrive in the same RUN cycle.
    failIter = 0;
    sameIter = 1;
    applyStimulus();
    finishRunA(1, 1'b0);
    sameIter = 0;

    // Reset asserted in the middle of the second iteration.
    applyStimulus();
    n = 0;
    while (!(iterA == 16'd1 && trstA) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("abort_reached_iter2", 32'(iterA), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    sbQ.delete();
    tick();
    checkOutput("abort_busy", 32'(busyA), 32'd0);
    checkOutput("abort_trst", 32'(trstA), 32'd0);
    checkOutput("abort_iter", 32'(iterA), 32'd0);
    checkOutput("abort_fail", 32'(failA), 32'd0);
    checkOutput("abort_done", 32'(doneA), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("abort_no_done", 32'(doneA), 32'd0);
    checkOutput("abort_idle", 32'(busyA), 32'd0);

`ifdef MEM_TEST_SEQ_TIMEOUT_EN
    // Tester never finishes: every iteration ends on the watchdog.
    modeA = 1;
    applyStimulus();
    finishRunA(3, 1'b1);
    modeA = 0;
`endif

    // Unbounded instance: stop during the fifth iteration.
    startB = 1'b1;
    tick();
    startB = 1'b0;
    n = 0;
    while (!(iterB == 16'd4 && trstB) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("B_reached_iter5", 32'(iterB), 32'd4);
    checkOutput("B_busy_running", 32'(busyB), 32'd1);
    stopB = 1'b1;
    tick();
    stopB = 1'b0;
    waitDoneB("B_done_wait");
    checkOutput("B_iter", 32'(iterB), 32'd5);
    checkOutput("B_fail", 32'(failB), 32'd0);
    checkOutput("B_pass", 32'(passB), 32'd1);
    checkOutput("B_tmo", 32'(tmoB), 32'd0);

    // Restart from DONE clears the counters; a stop latched in RESET ends after one iteration.
    startB = 1'b1;
    tick();
    startB = 1'b0;
    checkOutput("B_restart_iter", 32'(iterB), 32'd0);
    checkOutput("B_restart_busy", 32'(busyB), 32'd1);
    checkOutput("B_restart_done", 32'(doneB), 32'd0);
    stopB = 1'b1;
    tick();
    stopB = 1'b0;
    waitDoneB("B_done_wait2");
    checkOutput("B_iter_after_stop", 32'(iterB), 32'd1);
    checkOutput("B_pass2", 32'(passB), 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
